// File: rtl/handshake_rx_fifo.sv
// Valid/ready receiver that buffers upstream beats in a DEPTH-entry FIFO and
// forwards them downstream; ready may be gated by a periodic window.
module handshake_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned READY_MODE = 0,
  parameter int unsigned PERIOD     = 256,
  parameter int unsigned ON_START   = 9,
  parameter int unsigned OFF_START  = 22,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         soft_clr,
  input  logic                         vaild,
  input  logic [DATA_W-1:0]            master_data,
  output logic                         ready,
  output logic                         out_vaild,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic [CNT_W-1:0]             rx_count,
  output logic [DATA_W-1:0]            last_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned WIN_W = $clog2(PERIOD);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WIN_W-1:0]  win_cnt;

  logic              push_c;
  logic              pop_c;
  logic [LVL_W-1:0]  level_next_c;
  logic [WIN_W-1:0]  win_cnt_next_c;
  logic              win_next_c;
  logic              ready_next_c;

  assign push_c   = vaild & ready;
  assign pop_c    = out_vaild & out_ready;
  assign out_data = mem[rd_ptr];

  // Occupancy after this edge, window position after this edge, and the ready it implies
  always_comb begin
    level_next_c   = fill_level;
    win_cnt_next_c = win_cnt + WIN_W'(1);
    case ({push_c, pop_c})
      2'b10:   level_next_c = fill_level + LVL_W'(1);
      2'b01:   level_next_c = fill_level - LVL_W'(1);
      default: level_next_c = fill_level;
    endcase
    if (win_cnt == WIN_W'(PERIOD - 1)) begin
      win_cnt_next_c = '0;
    end
    win_next_c   = (win_cnt_next_c >= WIN_W'(ON_START)) &&
                   (win_cnt_next_c <  WIN_W'(OFF_START));
    ready_next_c = (level_next_c < LVL_W'(DEPTH)) &&
                   ((READY_MODE == 0) || win_next_c);
  end

  // Control state; soft_clr outranks every other update
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ready      <= 1'b0;
      out_vaild  <= 1'b0;
      fill_level <= '0;
      rx_count   <= '0;
      last_data  <= '0;
      win_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (soft_clr) begin
      ready      <= 1'b0;
      out_vaild  <= 1'b0;
      fill_level <= '0;
      rx_count   <= '0;
      last_data  <= '0;
      win_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      ready      <= ready_next_c;
      out_vaild  <= (level_next_c != '0);
      fill_level <= level_next_c;
      win_cnt    <= win_cnt_next_c;
      if (push_c) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        rx_count  <= rx_count + CNT_W'(1);
        last_data <= master_data;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: contents are only observed while out_vaild is high
  always_ff @(posedge sys_clk) begin
    if (push_c && !soft_clr) begin
      mem[wr_ptr] <= master_data;
    end
  end

endmodule

// File: tb/tb_handshake_rx_fifo.sv
// Scoreboard bench: a mode-0 instance for data-path scenarios and a mode-1
// instance for the periodic ready window.
module tb_handshake_rx_fifo;

  localparam int unsigned DEPTH = 8;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        soft_clr;
  logic        vaild;
  logic [7:0]  master_data;
  logic        ready;
  logic        out_vaild;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [3:0]  fill_level;
  logic [15:0] rx_count;
  logic [7:0]  last_data;

  logic        reset_b_n;
  logic        vaild_b;
  logic        ready_b;
  logic        out_vaild_b;
  logic [7:0]  out_data_b;
  logic [3:0]  fill_level_b;
  logic [15:0] rx_count_b;
  logic [7:0]  last_data_b;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  sb [$];
  bit          mdl_ready;

  always #5 sys_clk = ~sys_clk;

  handshake_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .READY_MODE(0)) u_dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .soft_clr(soft_clr), .vaild(vaild),
    .master_data(master_data), .ready(ready), .out_vaild(out_vaild),
    .out_data(out_data), .out_ready(out_ready), .fill_level(fill_level),
    .rx_count(rx_count), .last_data(last_data)
  );

  handshake_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .READY_MODE(1)) u_dut_win (
    .sys_clk(sys_clk), .reset_n(reset_b_n), .soft_clr(1'b0), .vaild(vaild_b),
    .master_data(8'h77), .ready(ready_b), .out_vaild(out_vaild_b),
    .out_data(out_data_b), .out_ready(1'b1), .fill_level(fill_level_b),
    .rx_count(rx_count_b), .last_data(last_data_b)
  );

  // Drive one cycle of stimulus and advance the reference model past the edge
  task automatic tick(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    bit push, pop;
    vaild = v; master_data = d; out_ready = ordy; soft_clr = clr;
    push = v && mdl_ready && !clr;
    pop  = ordy && (sb.size() != 0) && !clr;
    @(posedge sys_clk);
    if (clr) begin
      sb.delete();
      mdl_ready = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(d);
      mdl_ready = (sb.size() < DEPTH);
    end
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; soft_clr = 1'b0; vaild = 1'b0; master_data = '0; out_ready = 1'b0;
    mdl_ready = 1'b0;
    #12;
    total++; if (ready !== 1'b0)      begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++; if (out_vaild !== 1'b0)  begin bad++; $display("FAIL reset_out_vaild: got %b want 0", out_vaild); end
    total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    total++; if (rx_count !== 16'd0)  begin bad++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
    total++; if (last_data !== 8'd0)  begin bad++; $display("FAIL reset_last: got %h want 00", last_data); end
    reset_n = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (ready !== 1'b1)      begin bad++; $display("FAIL post_reset_ready: got %b want 1", ready); end
  endtask

  task automatic test_single;
    tick(1'b1, 8'hA5, 1'b1, 1'b0);
    total++; if (out_vaild !== 1'b1)  begin bad++; $display("FAIL single_vaild: got %b want 1", out_vaild); end
    total++; if (sb.size() == 0 || out_data !== sb[0]) begin bad++; $display("FAIL single_data: got %h want a5", out_data); end
    total++; if (rx_count !== 16'd1)  begin bad++; $display("FAIL single_rx_count: got %0d want 1", rx_count); end
    total++; if (last_data !== 8'hA5) begin bad++; $display("FAIL single_last: got %h want a5", last_data); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (out_vaild !== 1'b0)  begin bad++; $display("FAIL single_drained: got %b want 0", out_vaild); end
    total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL single_fill: got %0d want 0", fill_level); end
  endtask

  task automatic test_fill;
    int nxt;
    nxt = 1;
    for (int i = 0; i < 10; i++) begin
      if (mdl_ready) nxt++;
      tick(1'b1, 8'(i + 1), 1'b0, 1'b0);
      total++; if (ready !== mdl_ready) begin bad++; $display("FAIL fill_ready[%0d]: got %b want %b", i, ready, mdl_ready); end
    end
    total++; if (fill_level !== 4'd8) begin bad++; $display("FAIL fill_level_full: got %0d want 8", fill_level); end
    total++; if (ready !== 1'b0)      begin bad++; $display("FAIL fill_ready_full: got %b want 0", ready); end
    total++; if (rx_count !== 16'd9)  begin bad++; $display("FAIL fill_rx_count: got %0d want 9", rx_count); end
    for (int c = 0; c < 40; c++) begin
      bit p;
      if (sb.size() == 0 && nxt > 10) break;
      total++; if (out_vaild !== (sb.size() != 0)) begin bad++; $display("FAIL drain_vaild: got %b want %b", out_vaild, sb.size() != 0); end
      if (sb.size() != 0) begin
        total++; if (out_data !== sb[0]) begin bad++; $display("FAIL drain_data: got %h want %h", out_data, sb[0]); end
      end
      p = mdl_ready && (nxt <= 10);
      tick(nxt <= 10, 8'(nxt), 1'b1, 1'b0);
      if (p) nxt++;
      total++; if (ready !== mdl_ready) begin bad++; $display("FAIL drain_ready: got %b want %b", ready, mdl_ready); end
    end
    total++; if (sb.size() != 0 || nxt <= 10) begin bad++; $display("FAIL drain_timeout: left %0d want 0", sb.size()); end
    total++; if (rx_count !== 16'd11) begin bad++; $display("FAIL drain_rx_count: got %0d want 11", rx_count); end
  endtask

  task automatic test_concurrent;
    for (int i = 0; i < 7; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    total++; if (fill_level !== 4'd7) begin bad++; $display("FAIL conc_fill_start: got %0d want 7", fill_level); end
    total++; if (ready !== 1'b1)      begin bad++; $display("FAIL conc_ready_start: got %b want 1", ready); end
    for (int i = 0; i < 20; i++) begin
      total++; if (sb.size() == 0 || out_data !== sb[0]) begin bad++; $display("FAIL conc_data[%0d]: got %h want %h", i, out_data, (sb.size() != 0) ? sb[0] : 8'h00); end
      tick(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
      total++; if (fill_level !== 4'd7) begin bad++; $display("FAIL conc_fill[%0d]: got %0d want 7", i, fill_level); end
      total++; if (ready !== 1'b1)      begin bad++; $display("FAIL conc_ready[%0d]: got %b want 1", i, ready); end
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      total++; if (out_vaild !== 1'b1 || out_data !== sb[0]) begin bad++; $display("FAIL conc_drain: got %b/%h want 1/%h", out_vaild, out_data, sb[0]); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++; if (out_vaild !== 1'b0) begin bad++; $display("FAIL conc_empty: got %b want 0", out_vaild); end
  endtask

  task automatic test_soft_clr;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    total++; if (fill_level !== 4'd5) begin bad++; $display("FAIL clr_pre_fill: got %0d want 5", fill_level); end
    tick(1'b1, 8'hEE, 1'b0, 1'b1);
    total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL clr_fill: got %0d want 0", fill_level); end
    total++; if (out_vaild !== 1'b0)  begin bad++; $display("FAIL clr_vaild: got %b want 0", out_vaild); end
    total++; if (rx_count !== 16'd0)  begin bad++; $display("FAIL clr_rx_count: got %0d want 0", rx_count); end
    total++; if (ready !== 1'b0)      begin bad++; $display("FAIL clr_ready: got %b want 0", ready); end
    total++; if (last_data !== 8'd0)  begin bad++; $display("FAIL clr_last: got %h want 00", last_data); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (ready !== 1'b1)      begin bad++; $display("FAIL clr_ready_back: got %b want 1", ready); end
    total++; if (out_vaild !== 1'b0)  begin bad++; $display("FAIL clr_no_ghost: got %b want 0", out_vaild); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    sb.delete(); mdl_ready = 1'b0;
    #1;
    total++; if (ready !== 1'b0)      begin bad++; $display("FAIL rst_mid_ready: got %b want 0", ready); end
    total++; if (out_vaild !== 1'b0)  begin bad++; $display("FAIL rst_mid_vaild: got %b want 0", out_vaild); end
    total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL rst_mid_fill: got %0d want 0", fill_level); end
    total++; if (rx_count !== 16'd0)  begin bad++; $display("FAIL rst_mid_rx_count: got %0d want 0", rx_count); end
    total++; if (last_data !== 8'd0)  begin bad++; $display("FAIL rst_mid_last: got %h want 00", last_data); end
    #3 reset_n = 1'b1;
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b1, 8'h3C, 1'b1, 1'b0);
    total++; if (out_vaild !== 1'b1 || sb.size() == 0 || out_data !== sb[0]) begin bad++; $display("FAIL rst_resume_data: got %b/%h want 1/3c", out_vaild, out_data); end
    total++; if (rx_count !== 16'd1)  begin bad++; $display("FAIL rst_resume_rx_count: got %0d want 1", rx_count); end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (out_vaild !== 1'b0)  begin bad++; $display("FAIL rst_resume_empty: got %b want 0", out_vaild); end
  endtask

  task automatic test_window;
    int ph;
    bit exp_rdy;
    reset_b_n = 1'b0; vaild_b = 1'b1;
    @(negedge sys_clk);
    reset_b_n = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      @(posedge sys_clk); #1;
      ph = k % 256;
      exp_rdy = (ph >= 9) && (ph < 22);
      total++; if (ready_b !== exp_rdy) begin bad++; $display("FAIL win_ready[%0d]: got %b want %b", k, ready_b, exp_rdy); end
    end
    total++; if (rx_count_b !== 16'd26) begin bad++; $display("FAIL win_rx_count: got %0d want 26", rx_count_b); end
    total++; if (last_data_b !== 8'h77) begin bad++; $display("FAIL win_last: got %h want 77", last_data_b); end
    vaild_b = 1'b0;
  endtask

  initial begin
    reset_b_n = 1'b0; vaild_b = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_concurrent();
    test_soft_clr();
    test_reset_mid();
    test_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/handshake_rx_fifo.md
Name: handshake_rx_fifo

Overview:
- Parametrised successor to the single-word valid/ready slave receiver.
- Accepts beats from an upstream master over a vaild/ready handshake into a DEPTH-entry receive FIFO, then presents them downstream on a second vaild/ready interface.
- Backpressure is FIFO-driven, optionally gated by a programmable periodic ready window that reproduces the current test pattern.
- Exports fill level, beat count and last-received word for debug and scoreboard use.

Parameters:
- DATA_W, 8: data width of both interfaces.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- READY_MODE, 0: 0 = ready depends on FIFO space only; 1 = ready also gated by the periodic window.
- PERIOD, 256: window counter period in cycles, >= 2.
- ON_START, 9: window counter value at which the window opens.
- OFF_START, 22: window counter value at which the window closes; ON_START < OFF_START < PERIOD.
- CNT_W, 16: width of rx_count.

Ports:
- sys_clk  in  1  system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous flush of FIFO, counters and last_data.
- vaild  in  1  upstream beat valid.
- master_data  in  DATA_W  upstream beat data.
- ready  out  1  upstream ready; registered.
- out_vaild  out  1  downstream valid; high when FIFO not empty.
- out_data  out  DATA_W  FIFO head word (first-word fall-through).
- out_ready  in  1  downstream ready.
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- rx_count  out  CNT_W  accepted upstream beats, wraps to 0.
- last_data  out  DATA_W  most recently accepted upstream word.

Behaviour:
- Reset (reset_n low, asynchronous): ready=0, FIFO empty, out_vaild=0, fill_level=0, rx_count=0, last_data=0, window counter=0, read/write pointers=0.
- Push: on an edge with vaild & ready, the beat is written. Pop: on an edge with out_vaild & out_ready, the head is removed.
- Latency: a word pushed at edge N appears on out_data with out_vaild=1 after edge N (one cycle), when the FIFO was empty.
- Window counter: increments every cycle and wraps PERIOD-1 -> 0. win_next is 1 for counter_next in [ON_START, OFF_START).
- ready register: next value = (count_next < DEPTH) && (READY_MODE==0 || win_next).
  - count_next is the occupancy after this edge's push/pop, so ready=1 always guarantees one free slot.
  - A push is never lost or overwritten.
- fill_level: push only -> +1; pop only -> -1; both or neither -> unchanged. It never exceeds DEPTH and never goes below 0.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from fill_level.
- Simultaneous push and pop when fill_level==DEPTH-1: both succeed, level unchanged, ready stays 1.
- Pop when empty cannot occur because out_vaild=0. Data on out_data while out_vaild=0 is don't-care.
- rx_count increments on every push and wraps 2^CNT_W-1 -> 0. last_data loads master_data on every push.
- soft_clr=1 at an edge:
  - FIFO is emptied; rx_count=0, last_data=0, window counter=0, ready=0.
  - Any push or pop coincident with soft_clr is discarded and not counted.
  - soft_clr has priority over all other updates.
- Reset asserted mid-transfer: all state cleared immediately. Beats in flight are lost; no partial state survives.
- vaild may rise or fall independently of ready. The block makes no assumption about master_data stability when vaild=0.

Test Plan:
- Single beat, READY_MODE=0, out_ready=1: reset release, then vaild=1 with data 0xA5 for one ready cycle -> out_vaild=1 with 0xA5 next cycle, then 0; rx_count=1, last_data=0xA5.
- Fill to full, out_ready=0, DEPTH=8: stream 0x01..0x0A -> exactly 8 accepted, ready=0 after the 8th push, fill_level=8. Release out_ready -> 0x01..0x08 in order, then 0x09, 0x0A accepted.
- Concurrent push/pop at DEPTH-1, vaild=1, out_ready=1 continuously -> fill_level constant, ready stays 1, no gaps, order preserved.
- READY_MODE=1 defaults, vaild held high -> ready high only during counter 9..21 each 256-cycle period; 13 beats accepted per period; rx_count=26 after two periods.
- soft_clr with 5 words queued and a coincident push -> next cycle fill_level=0, out_vaild=0, rx_count=0, ready=0; the coincident beat does not appear downstream.
- reset_n pulsed low mid-stream for a half cycle -> all outputs are at reset values immediately and asynchronously; operation resumes cleanly after release.
